// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation at a time to a combinational ALU.
// It holds the ALU inputs for an op-dependent settle time, captures the
// 64-bit result into z_hi/z_lo, and returns it over a valid/ready handshake.
// Optional build macro ALU_ISSUE_STATS_EN adds stat_ops/stat_errs counters.
module alu_issue_ctrl #(
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8,
  parameter int BASE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_brn,
  output logic [31:0] alu_in_a,
  output logic [31:0] alu_in_b,
  output logic [4:0]  alu_op_code,
  output logic [31:0] alu_brn_flag,
  input  logic [63:0] alu_out,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        resp_err
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_errs
`endif
);

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  // Counter must hold the longest settle time of any op.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ?
                           ((MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT) :
                           ((DIV_LAT > BASE_LAT) ? DIV_LAT : BASE_LAT);
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   lat_sel;
  logic               op_legal;
  logic               req_good;

  // Decode the request: legality and settle time for the incoming op.
  always_comb begin
    op_legal = 1'b0;
    lat_sel  = CNT_W'(BASE_LAT);
    case (req_op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_NEG, OP_NOT: op_legal = 1'b1;
      OP_MUL: begin
        op_legal = 1'b1;
        lat_sel  = CNT_W'(MUL_LAT);
      end
      OP_DIV: begin
        op_legal = 1'b1;
        lat_sel  = CNT_W'(DIV_LAT);
      end
      default: op_legal = 1'b0;
    endcase
    req_good = op_legal && !((req_op == OP_DIV) && (req_b == 32'd0));
  end

  // State register; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs derived from the current state.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_good ? EXEC : DONE;
      end
      EXEC: begin
        if (cnt == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch ALU inputs on a good request, count down, capture result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_op_code  <= '0;
      alu_brn_flag <= '0;
      cnt          <= '0;
      z_hi         <= '0;
      z_lo         <= '0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_good) begin
            alu_in_a     <= req_a;
            alu_in_b     <= req_b;
            alu_op_code  <= req_op;
            alu_brn_flag <= req_brn;
            cnt          <= lat_sel;
          end else if (req_valid) begin
            z_hi     <= '0;
            z_lo     <= '0;
            resp_err <= 1'b1;
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            z_hi     <= alu_out[63:32];
            z_lo     <= alu_out[31:0];
            resp_err <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Count completed response handshakes, split by error status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (state == DONE && resp_ready) begin
      if (resp_err) stat_errs <= stat_errs + 16'd1;
      else          stat_ops  <= stat_ops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed requests with hand-computed results,
// a scoreboard queue filled by the driver and drained by a negedge monitor.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_brn;
  logic [31:0] alu_in_a;
  logic [31:0] alu_in_b;
  logic [4:0]  alu_op_code;
  logic [31:0] alu_brn_flag;
  logic [63:0] alu_out;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        resp_err;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_brn;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic [4:0]  last_op;
  logic [31:0] last_a;
  logic [31:0] last_b;
  logic [31:0] last_brn;

  alu_issue_ctrl #(
    .MUL_LAT(4),
    .DIV_LAT(8),
    .BASE_LAT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .req_brn(req_brn),
    .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b),
    .alu_op_code(alu_op_code),
    .alu_brn_flag(alu_brn_flag),
    .alu_out(alu_out),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .z_hi(z_hi),
    .z_lo(z_lo),
    .resp_err(resp_err)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops(stat_ops),
    .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU feeding the controller: divide gives quotient on LO, remainder on HI.
  logic [63:0] dbl;
  always_comb begin
    dbl     = {alu_in_a, alu_in_a};
    alu_out = 64'd0;
    case (alu_op_code)
      5'b00011: alu_out = {32'd0, alu_in_a + alu_in_b};
      5'b00100: alu_out = {32'd0, alu_in_a - alu_in_b};
      5'b00101: alu_out = {32'd0, alu_in_a >> alu_in_b[4:0]};
      5'b00110: alu_out = {32'd0, alu_in_a << alu_in_b[4:0]};
      5'b00111: alu_out = {32'd0, 32'(dbl >> alu_in_b[4:0])};
      5'b01000: begin
        dbl     = dbl << alu_in_b[4:0];
        alu_out = {32'd0, dbl[63:32]};
      end
      5'b01001: alu_out = {32'd0, alu_in_a & alu_in_b};
      5'b01010: alu_out = {32'd0, alu_in_a | alu_in_b};
      5'b01110: alu_out = {32'd0, alu_in_a} * {32'd0, alu_in_b};
      5'b01111: if (alu_in_b != 32'd0) alu_out = {alu_in_a % alu_in_b, alu_in_a / alu_in_b};
      5'b10000: alu_out = {32'd0, -alu_in_a};
      5'b10001: alu_out = {32'd0, ~alu_in_a};
      default:  alu_out = 64'd0;
    endcase
  end

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Issue one request; the expected response goes on the scoreboard first.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] brn, input logic [31:0] hi, input logic [31:0] lo,
                               input logic err, input int lat, input bit wait_done);
    exp_t e;
    if (!err) begin
      last_op  = op;
      last_a   = a;
      last_b   = b;
      last_brn = brn;
    end
    e.alu_op  = last_op;
    e.alu_a   = last_a;
    e.alu_b   = last_b;
    e.alu_brn = last_brn;
    e.hi      = hi;
    e.lo      = lo;
    e.err     = err;
    e.lat     = lat;
    sb.push_back(e);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_brn   = brn;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (wait_done) waitIdle();
  endtask

  // Wait, bounded, until the monitor has retired every expected response.
  task automatic waitIdle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic checkReset();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
    checkOutput("rst_z", {z_hi, z_lo}, 64'd0);
    checkOutput("rst_alu_ab", {alu_in_a, alu_in_b}, 64'd0);
    checkOutput("rst_alu_op", 64'(alu_op_code), 64'd0);
    checkOutput("rst_alu_brn", 64'(alu_brn_flag), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
    checkOutput("rst_stats", {stat_ops, stat_errs}, 64'd0);
`endif
  endtask

  // Monitor: on each falling edge compare the DUT against the scoreboard head.
  bit accepted = 0;
  bit seen = 0;
  bit check_rdy = 0;
  int e0 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      accepted  = 0;
      seen      = 0;
      check_rdy = 0;
    end else begin
      if (check_rdy) begin
        checkOutput("req_ready_after_resp", 64'(req_ready), 64'd1);
        check_rdy = 0;
      end
      if (accepted && sb.size() != 0) begin
        checkOutput("alu_op_hold", 64'(alu_op_code), 64'(sb[0].alu_op));
        checkOutput("alu_ab_hold", {alu_in_a, alu_in_b}, {sb[0].alu_a, sb[0].alu_b});
        checkOutput("alu_brn_hold", 64'(alu_brn_flag), 64'(sb[0].alu_brn));
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          if (!seen) begin
            checkOutput("latency", 64'(cyc - e0), 64'(sb[0].lat));
            seen = 1;
          end
          checkOutput("z_hi", 64'(z_hi), 64'(sb[0].hi));
          checkOutput("z_lo", 64'(z_lo), 64'(sb[0].lo));
          checkOutput("resp_err", 64'(resp_err), 64'(sb[0].err));
          if (resp_ready) begin
            void'(sb.pop_front());
            accepted  = 0;
            seen      = 0;
            check_rdy = 1;
          end
        end
      end
      if (req_valid && req_ready) begin
        accepted = 1;
        seen     = 0;
        e0       = cyc + 1;
      end
    end
  end

  // Directed sequence.
  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 5'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    req_brn    = 32'd0;
    resp_ready = 1'b1;
    last_op    = 5'd0;
    last_a     = 32'd0;
    last_b     = 32'd0;
    last_brn   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkReset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(5'b00011, 32'd10, 32'd2, 32'h11, 32'd0, 32'd12, 1'b0, 1, 1'b1);

    // Reset for one edge while a multiply is in its settle window.
    applyStimulus(5'b01110, 32'd10, 32'd2, 32'h22, 32'd0, 32'd20, 1'b0, 4, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkReset();
    rst_n    = 1'b1;
    last_op  = 5'd0;
    last_a   = 32'd0;
    last_b   = 32'd0;
    last_brn = 32'd0;
    repeat (6) begin
      @(posedge clk);
      #1;
      checkOutput("no_resp_after_reset", 64'(resp_valid), 64'd0);
    end

    applyStimulus(5'b00011, 32'd1, 32'd1, 32'h0, 32'd0, 32'd2, 1'b0, 1, 1'b1);
    applyStimulus(5'b01110, 32'd10, 32'd2, 32'h5, 32'd0, 32'd20, 1'b0, 4, 1'b1);
    applyStimulus(5'b10001, 32'd10, 32'd0, 32'h0, 32'd0, 32'hFFFFFFF5, 1'b0, 1, 1'b1);
    applyStimulus(5'b01111, 32'd10, 32'd2, 32'h7, 32'd0, 32'd5, 1'b0, 8, 1'b1);
    applyStimulus(5'b01111, 32'd10, 32'd0, 32'h9, 32'd0, 32'd0, 1'b1, 0, 1'b1);
    applyStimulus(5'b01111, 32'd17, 32'd5, 32'h0, 32'd2, 32'd3, 1'b0, 8, 1'b1);
    applyStimulus(5'b01110, 32'h10000, 32'h10000, 32'h0, 32'd1, 32'd0, 1'b0, 4, 1'b1);
    applyStimulus(5'b01000, 32'h80000001, 32'd1, 32'h0, 32'd0, 32'd3, 1'b0, 1, 1'b1);
    applyStimulus(5'b11111, 32'd3, 32'd4, 32'h0, 32'd0, 32'd0, 1'b1, 0, 1'b1);
    applyStimulus(5'b01011, 32'd3, 32'd4, 32'h0, 32'd0, 32'd0, 1'b1, 0, 1'b1);
    applyStimulus(5'b00100, 32'd10, 32'd2, 32'h0, 32'd0, 32'd8, 1'b0, 1, 1'b1);

    // Consumer stalls for three cycles; a second request must be refused.
    resp_ready = 1'b0;
    applyStimulus(5'b00100, 32'd100, 32'd1, 32'h3, 32'd0, 32'd99, 1'b0, 1, 1'b0);
    for (int i = 0; i < 50 && !resp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stall_resp_valid", 64'(resp_valid), 64'd1);
    req_op    = 5'b00011;
    req_a     = 32'd55;
    req_b     = 32'd66;
    req_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
      checkOutput("stall_resp_valid_hold", 64'(resp_valid), 64'd1);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    waitIdle();

`ifdef ALU_ISSUE_STATS_EN
    @(posedge clk);
    #1;
    checkOutput("stat_ops", 64'(stat_ops), 64'd9);
    checkOutput("stat_errs", 64'(stat_errs), 64'd3);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if something wedges the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
